// File: rtl/x_dl_pkg.sv
// Shared definitions for the delay-line sample protocol (host and device side).
package x_dl_pkg;

    // Host-side initiator states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } dl_host_state_t;

    // Command byte that asks the device for one delay-line sample.
    localparam logic [7:0] DL_CMD_SAMPLE = 8'h01;

    // Number of bytes in one response (little-endian 32-bit sample).
    localparam int DL_RESP_BYTES = 4;

    // Width of the response byte index.
    localparam int DL_IDX_W = 2;

    // True when idx addresses the final byte of a response.
    function automatic logic dl_is_last_byte(input logic [DL_IDX_W-1:0] idx);
        return idx == DL_IDX_W'(DL_RESP_BYTES - 1);
    endfunction

endpackage

// File: rtl/x_timeout_ctr.sv
// Loadable down-counter used as a per-byte inactivity timer.
// o_expired is high whenever the count is zero; the counter holds at zero.
module x_timeout_ctr #(
    parameter int p_width = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [p_width-1:0] i_load_value,
    input  logic               i_en,
    output logic               o_expired
);

    logic [p_width-1:0] count;

    // Load has priority over counting; count saturates at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_value;
        end else if (i_en && (count != '0)) begin
            count <= count - p_width'(1);
        end
    end

    assign o_expired = (count == '0);

endmodule

// File: rtl/x_dl_host.sv
// Host-side initiator: sends one capture command byte, then assembles the
// four-byte little-endian response into a 32-bit sample.
//
// Handshakes: the command byte is offered with o_tx_valid and held stable until
// the cycle where o_tx_valid and i_tx_accept are both high; that cycle transfers
// it. Received bytes are single-cycle i_rx_valid strobes with no backpressure.
// o_valid and o_timeout are single-cycle strobes and are never high together.
module x_dl_host
    import x_dl_pkg::*;
#(
    parameter logic [7:0] p_cmd     = DL_CMD_SAMPLE,
    parameter int         p_timeout = 1_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_accept,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    output logic                 o_valid,
    output logic [31:0]          o_data,
    output logic                 o_timeout,
    output dl_host_state_t       o_dbg_state
);

    localparam int CTR_W = $clog2(p_timeout + 1);
    // Loaded with one less than the budget so the abort lands exactly
    // p_timeout cycles after the last accepted byte or command.
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(p_timeout - 1);

    dl_host_state_t        state;
    dl_host_state_t        state_nxt;
    logic [DL_IDX_W-1:0]   idx;
    logic [31:0]           shift;
    logic [31:0]           shift_nxt;
    logic                  ctr_load;
    logic                  ctr_en;
    logic                  expired;
    logic                  rx_take;
    logic                  rx_last;

    // A byte is only consumed while collecting the response.
    assign rx_take = (state == RECV) && i_rx_valid;
    assign rx_last = rx_take && dl_is_last_byte(idx);

    assign o_tx_data   = p_cmd;
    assign o_dbg_state = state;

    x_timeout_ctr #(
        .p_width(CTR_W)
    ) u_timeout_ctr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (ctr_load),
        .i_load_value(CTR_LOAD),
        .i_en        (ctr_en),
        .o_expired   (expired)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, strobes and timer control. A byte arriving on the expiring
    // cycle wins over the timeout. Strobes are masked during reset so an
    // aborted capture never reports completion or timeout.
    always_comb begin
        state_nxt  = state;
        ctr_load   = 1'b0;
        ctr_en     = 1'b0;
        o_busy     = (state != IDLE);
        o_tx_valid = 1'b0;
        o_valid    = 1'b0;
        o_timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                o_tx_valid = 1'b1;
                if (i_tx_accept) begin
                    ctr_load  = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (i_rx_valid) begin
                    ctr_load = 1'b1;
                    if (dl_is_last_byte(idx)) begin
                        state_nxt = DONE;
                    end
                end else if (expired) begin
                    o_timeout = ~i_rst;
                    state_nxt = IDLE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE: begin
                o_valid   = ~i_rst;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift register with the incoming byte merged at its little-endian slot.
    always_comb begin
        shift_nxt = shift;
        shift_nxt[8*idx +: 8] = i_rx_data;
    end

    // Byte index, shift register and output sample. The sample is updated on
    // the edge that takes the final byte so it is visible with o_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx    <= '0;
            shift  <= '0;
            o_data <= '0;
        end else begin
            if ((state == SEND) && i_tx_accept) begin
                idx <= '0;
            end else if (rx_take) begin
                idx   <= idx + DL_IDX_W'(1);
                shift <= shift_nxt;
            end
            if (rx_last) begin
                o_data <= shift_nxt;
            end
        end
    end

endmodule

// File: tb/tb_x_dl_host.sv
// Bench for x_dl_host: two instances (default timeout and p_timeout=20) share
// one set of stimulus lines steered by sel; outputs are muxed back by sel.
module tb_x_dl_host;
    import x_dl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic       tx_accept = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic a_busy, a_tx_valid, a_valid, a_timeout;
    logic b_busy, b_tx_valid, b_valid, b_timeout;
    logic [7:0]  a_tx_data, b_tx_data;
    logic [31:0] a_data, b_data;
    dl_host_state_t a_state, b_state;

    x_dl_host dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .o_busy(a_busy),
        .o_tx_valid(a_tx_valid), .o_tx_data(a_tx_data), .i_tx_accept(tx_accept & ~sel),
        .i_rx_valid(rx_valid & ~sel), .i_rx_data(rx_data), .o_valid(a_valid),
        .o_data(a_data), .o_timeout(a_timeout), .o_dbg_state(a_state)
    );

    x_dl_host #(.p_timeout(20)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start & sel), .o_busy(b_busy),
        .o_tx_valid(b_tx_valid), .o_tx_data(b_tx_data), .i_tx_accept(tx_accept & sel),
        .i_rx_valid(rx_valid & sel), .i_rx_data(rx_data), .o_valid(b_valid),
        .o_data(b_data), .o_timeout(b_timeout), .o_dbg_state(b_state)
    );

    logic        busy, tx_valid, valid, timeout;
    logic [7:0]  tx_data;
    logic [31:0] data;
    dl_host_state_t state;
    assign busy     = sel ? b_busy     : a_busy;
    assign tx_valid = sel ? b_tx_valid : a_tx_valid;
    assign tx_data  = sel ? b_tx_data  : a_tx_data;
    assign valid    = sel ? b_valid    : a_valid;
    assign data     = sel ? b_data     : a_data;
    assign timeout  = sel ? b_timeout  : a_timeout;
    assign state    = sel ? b_state    : a_state;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int valid_cnt = 0;
    int to_cnt = 0;
    int to_cyc = 0;
    int hs_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_o_valid", 32'd1, 32'd0);
            end else begin
                chk("sample", data, exp_q.pop_front());
            end
            chk("valid_and_timeout", {31'd0, timeout}, 32'd0);
        end
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (tx_valid && tx_accept) hs_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tx_valid_after_start", {31'd0, tx_valid}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic accept_after(input int d);
        repeat (d) begin
            chk("tx_valid_held", {31'd0, tx_valid}, 32'd1);
            chk("tx_data_held", {24'd0, tx_data}, 32'h01);
            tick();
        end
        chk("tx_valid_at_accept", {31'd0, tx_valid}, 32'd1);
        tx_accept = 1'b1;
        tick();
        tx_accept = 1'b0;
        chk("state_recv", {30'd0, state}, {30'd0, RECV});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Feeds four bytes (gap < 0 means random 0..5 idle cycles before each);
    // ends in the DONE cycle, checks it, then steps into IDLE.
    task automatic feed(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [31:0] exp, input int gap,
                        input bit poke_start);
        logic [7:0] bs[4];
        int vc0;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        vc0 = valid_cnt;
        exp_q.push_back(exp);
        for (int i = 0; i < 4; i++) begin
            repeat ((gap < 0) ? $urandom_range(0, 5) : gap) tick();
            if (poke_start && i == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            send_byte(bs[i]);
        end
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_valid", {31'd0, valid}, 32'd1);
        chk("done_data", data, exp);
        tick();
        chk("valid_pulses", valid_cnt - vc0, 32'd1);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        chk("valid_one_cycle", {31'd0, valid}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  b[4];
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[5];

    int tc0, vc0, hs0, t_b;
    logic [31:0] prior;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].b = '{8'h78, 8'h56, 8'h34, 8'h12}; vecs[0].exp = 32'h12345678;
        vecs[1].b = '{8'hFF, 8'h00, 8'hFF, 8'h00}; vecs[1].exp = 32'h00FF00FF;
        vecs[2].b = '{8'h01, 8'h80, 8'h7F, 8'hFE}; vecs[2].exp = 32'hFE7F8001;
        vecs[3].b = '{8'hC3, 8'h3C, 8'hA5, 8'h5A}; vecs[3].exp = 32'h5AA53CC3;
        vecs[4].b = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[4].exp = 32'h00000000;

        // reset state of both instances
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
            chk("rst_tx_data", {24'd0, tx_data}, 32'h01);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_timeout", {31'd0, timeout}, 32'd0);
            chk("rst_data", data, 32'd0);
            chk("rst_state", {30'd0, state}, {30'd0, IDLE});
        end
        sel = 1'b0;
        rst = 1'b0;
        tick();

        // table-driven captures on the default-timeout instance
        for (int i = 0; i < 5; i++) begin
            hs0 = hs_cnt;
            do_start();
            accept_after((i == 0) ? 3 : $urandom_range(0, 4));
            chk("one_handshake", hs_cnt - hs0, 32'd1);
            feed(vecs[i].b[0], vecs[i].b[1], vecs[i].b[2], vecs[i].b[3], vecs[i].exp,
                 (i == 0) ? 100 : -1, 1'b0);
        end

        // stray bytes in IDLE, then a capture with i_start poked during RECV
        send_byte(8'h99);
        send_byte(8'h98);
        chk("stray_idle", {30'd0, state}, {30'd0, IDLE});
        hs0 = hs_cnt;
        do_start();
        accept_after(1);
        feed(8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCCBBAA, 2, 1'b1);
        repeat (5) tick();
        chk("no_second_cmd", hs_cnt - hs0, 32'd1);
        chk("idle_after_poke", {31'd0, busy}, 32'd0);

        // timeout instance: backpressure 50 cycles in SEND, no timeout counted
        sel = 1'b1;
        tick();
        tc0 = to_cnt;
        do_start();
        accept_after(50);
        chk("no_timeout_in_send", to_cnt - tc0, 32'd0);
        feed(8'h44, 8'h33, 8'h22, 8'h11, 32'h11223344, 0, 1'b0);
        prior = 32'h11223344;

        // timeout 20 cycles after the second byte
        do_start();
        accept_after(0);
        send_byte(8'hA1);
        repeat (3) tick();
        t_b = cyc;
        send_byte(8'hA2);
        tc0 = to_cnt;
        for (int k = 0; k < 40 && to_cnt == tc0; k++) tick();
        chk("timeout_pulses", to_cnt - tc0, 32'd1);
        chk("timeout_latency", to_cyc - t_b, 32'd20);
        chk("idle_after_timeout", {30'd0, state}, {30'd0, IDLE});
        chk("data_kept", data, prior);
        do_start();
        accept_after(2);
        feed(8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 3, 1'b0);

        // boundary: every byte lands on the expiring cycle
        tc0 = to_cnt;
        do_start();
        accept_after(0);
        feed(8'h5A, 8'h6B, 8'h7C, 8'h8D, 32'h8D7C6B5A, 19, 1'b0);
        chk("boundary_no_timeout", to_cnt - tc0, 32'd0);

        // reset in the middle of RECV
        sel = 1'b0;
        tick();
        do_start();
        accept_after(0);
        send_byte(8'hE1);
        send_byte(8'hE2);
        vc0 = valid_cnt;
        tc0 = to_cnt;
        rst = 1'b1;
        tick();
        chk("mid_rst_state", {30'd0, state}, {30'd0, IDLE});
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, tx_data}, 32'h01);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        chk("mid_rst_data", data, 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk("mid_rst_no_valid", valid_cnt - vc0, 32'd0);
        chk("mid_rst_no_timeout", to_cnt - tc0, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/x_dl_host.md
# x_dl_host

Host-side initiator for the delay-line sample protocol. It sends a one-byte capture command into a UART transmit byte stream, then collects the four-byte little-endian response from a UART receive byte stream. It presents the assembled 32-bit delay-line sample with a one-cycle valid strobe. It sits between `x_uart_tx`/`x_uart_rx` instances on the host/test side of the link, opposite the device-side `x_driver`.

## Interface
Parameters:
- `p_cmd`, default 8'h01: command byte that requests one delay-line sample.
- `p_timeout`, default 1_000_000: cycles to wait for each response byte before aborting. Legal range is ≥ 2.

Ports:
- `i_clk`  in  1: clock. One clock; reset is synchronous and active-high.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_start`  in  1: request one capture. Sampled only in IDLE.
- `o_busy`  out  1: high whenever the state is not IDLE.
- `o_tx_valid`  out  1: command byte valid, to `x_uart_tx` `i_valid`.
- `o_tx_data`  out  8: command byte, to `x_uart_tx` `i_data`.
- `i_tx_accept`  in  1: byte taken, from `x_uart_tx` `o_accept`.
- `i_rx_valid`  in  1: one-cycle strobe for a received byte, from `x_uart_rx` `o_valid`.
- `i_rx_data`  in  8: received byte.
- `o_valid`  out  1: one-cycle strobe; `o_data` holds a complete sample.
- `o_data`  out  32: assembled sample. Held until the next successful capture.
- `o_timeout`  out  1: one-cycle strobe; the capture was aborted.

## Operation
- States are IDLE, SEND, RECV and DONE.
- IDLE:
  - On `i_start`, go to SEND.
  - `i_rx_valid` bytes arriving in IDLE are discarded.
- SEND:
  - `o_tx_valid`=1 and `o_tx_data`=`p_cmd`.
  - On `i_tx_accept`=1 (same cycle as valid), go to RECV. Clear the byte index to 0 and load the timeout counter.
  - `o_tx_valid` stays high until accepted. The data is stable while valid.
- RECV:
  - On each `i_rx_valid`, write `i_rx_data` into `shift[8*idx +: 8]`, increment `idx`, and reload the timeout counter.
  - When the fourth byte arrives (idx==3), go to DONE.
  - Otherwise the timeout counter decrements each cycle. When it reaches 0 with no byte that cycle, pulse `o_timeout` and go to IDLE. `o_data` is left unchanged.
  - A byte arriving in the same cycle the counter reaches 0 is accepted and the timeout is not raised; the byte wins.
- DONE:
  - Copy the shift register into `o_data`, pulse `o_valid`, and return to IDLE.
- Byte order is little-endian: the first received byte is `o_data[7:0]` and the fourth is `o_data[31:24]`.
- `i_start` while busy is ignored; it is not queued.
- Counters:
  - `idx` is 2 bits.
  - The timeout counter is $clog2(p_timeout+1) bits and is loaded with `p_timeout`-1.
  - No wrap-around is reachable.

## Timing
- Reset values:
  - state is IDLE.
  - `o_busy`, `o_tx_valid`, `o_valid` and `o_timeout` are 0.
  - `o_tx_data`=`p_cmd` (constant).
  - `o_data`=32'h0, the shift register is 0, and `idx` is 0.
- `i_start` at cycle N gives `o_tx_valid`=1 at N+1 (registered state).
- The SEND→RECV transition happens on the edge after the valid&accept cycle.
- The fourth `i_rx_valid` at cycle M moves the block to DONE at M+1. `o_valid` and the new `o_data` are visible at M+1. IDLE follows at M+2.
- `o_busy` is combinational from state and is high from N+1 through the DONE cycle inclusive.
- Timeout: if the last byte (or the accept) is at cycle T and no further byte arrives, `o_timeout` pulses at T+`p_timeout`. IDLE follows on the next cycle.
- Reset mid-operation:
  - Return to IDLE on the next edge and drop any partial bytes.
  - `o_data` is cleared to 0.
  - No `o_valid` or `o_timeout` pulse is generated.
- `o_valid` and `o_timeout` are never high in the same cycle.

## Structure
- Shared package `x_dl_pkg`:
  - state enum `dl_host_state_t` (IDLE, SEND, RECV, DONE).
  - `DL_CMD_SAMPLE` = 8'h01, the default for `p_cmd`; `x_driver` also uses it.
  - `DL_RESP_BYTES` = 4.
- One sub-module, `x_timeout_ctr`. It is a loadable down-counter with `i_load`, `i_en` and an `o_expired` output, and it is reusable by the driver.
- The state machine, byte index and shift register live in the top.

## Test plan
- Single capture: assert `i_start`; the bench accepts the command after 3 cycles, then feeds bytes 0x78, 0x56, 0x34, 0x12 with 100-cycle gaps. Required: one `o_tx_valid` handshake with data 0x01, then `o_valid` for exactly one cycle with `o_data`=32'h12345678, and `o_busy` low afterwards.
- Backpressure: hold `i_tx_accept`=0 for 50 cycles. Required: `o_tx_valid` stays high with data 0x01 throughout, and there is no timeout count in SEND.
- Timeout: `p_timeout`=20; send 2 bytes, then stop. Required: `o_timeout` pulses exactly 20 cycles after the second byte, `o_data` keeps its prior value, and a fresh capture of bytes 0x01..0x04 gives 32'h04030201.
- Boundary: a byte arrives exactly on the expiring cycle. Required: the byte is accepted, there is no `o_timeout`, and the capture completes.
- Stray/overlap:
  - `i_rx_valid` bytes arriving in IDLE are ignored; the next capture of 0xAA, 0xBB, 0xCC, 0xDD gives 32'hDDCCBBAA.
  - `i_start` pulsed during RECV starts no second command.
- Reset mid-RECV: assert `i_rst` after 2 bytes. Required: the next cycle is IDLE with all outputs at reset values, and no `o_valid` or `o_timeout` pulse.
